// File: rtl/hack_kbd_ps2_pkg.sv
// Shared constants for the Hack PS/2 keyboard front end: Hack key codes,
// scan-code prefixes and the receiver state encoding.
package hack_kbd_pkg;

    // Set-2 prefix bytes
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    // Hack special-key codes
    localparam logic [7:0] KEY_NEWLINE   = 8'd128;
    localparam logic [7:0] KEY_BACKSPACE = 8'd129;
    localparam logic [7:0] KEY_LEFT      = 8'd130;
    localparam logic [7:0] KEY_UP        = 8'd131;
    localparam logic [7:0] KEY_RIGHT     = 8'd132;
    localparam logic [7:0] KEY_DOWN      = 8'd133;
    localparam logic [7:0] KEY_HOME      = 8'd134;
    localparam logic [7:0] KEY_END       = 8'd135;
    localparam logic [7:0] KEY_PGUP      = 8'd136;
    localparam logic [7:0] KEY_PGDN      = 8'd137;
    localparam logic [7:0] KEY_INSERT    = 8'd138;
    localparam logic [7:0] KEY_DELETE    = 8'd139;
    localparam logic [7:0] KEY_ESC       = 8'd140;
    localparam logic [7:0] KEY_F1        = 8'd141;
    localparam logic [7:0] KEY_F2        = 8'd142;
    localparam logic [7:0] KEY_F3        = 8'd143;
    localparam logic [7:0] KEY_F4        = 8'd144;
    localparam logic [7:0] KEY_F5        = 8'd145;
    localparam logic [7:0] KEY_F6        = 8'd146;
    localparam logic [7:0] KEY_F7        = 8'd147;
    localparam logic [7:0] KEY_F8        = 8'd148;
    localparam logic [7:0] KEY_F9        = 8'd149;
    localparam logic [7:0] KEY_F10       = 8'd150;
    localparam logic [7:0] KEY_F11       = 8'd151;
    localparam logic [7:0] KEY_F12       = 8'd152;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/hack_kbd_ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, falling-edge detect,
// frame FSM with odd-parity/stop checking and inter-edge timeout.
module ps2_rx
    import hack_kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic            clk_s1_q, clk_s2_q, clk_prev_q;
    logic            dat_s1_q, dat_s2_q;
    logic            fall;
    rx_state_e       state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [TW-1:0]   tmo_q;
    logic [7:0]      byte_q;
    logic            byte_valid_q;
    logic            frame_err_q;

    // Two-flop synchronisers plus previous-value flop for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_i;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data_i;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    // Frame FSM; an edge always takes priority over an expiring timeout
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RX_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (fall) begin
                tmo_q <= '0;
                case (state_q)
                    RX_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= RX_DATA;
                            bit_cnt_q <= '0;
                            par_q     <= 1'b0;
                        end
                    end
                    RX_DATA: begin
                        shift_q <= {dat_s2_q, shift_q[7:1]};
                        par_q   <= par_q ^ dat_s2_q;
                        if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
                        else                   bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    RX_PARITY: begin
                        par_q   <= par_q ^ dat_s2_q;
                        state_q <= RX_STOP;
                    end
                    RX_STOP: begin
                        state_q <= RX_IDLE;
                        if (par_q && dat_s2_q) begin
                            byte_q       <= shift_q;
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q  <= 1'b1;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end else if (state_q != RX_IDLE) begin
                // tmo_q counts idle cycles since the last edge; the abort
                // fires on the TIMEOUT_CYCLES-th one
                if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_q     <= RX_IDLE;
                    tmo_q       <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end
        end
    end

    assign rx_byte_o    = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/hack_kbd_ps2.sv
// Hack KBD register writer: PS/2 receiver, set-2 make/break decoding and
// the held-key register read by the CPU at address 24576.
module hack_kbd_ps2
    import hack_kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kbd_out,
    output logic        key_event,
    output logic        frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] hack_code;
    logic       ext_q, brk_q;
    logic [7:0] kbd_q;
    logic       key_event_q;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .rx_byte_o    (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (frame_err)
    );

    // Scan-code lookup on {ext, byte}; 0 means unmapped
    always_comb begin
        hack_code = '0;
        if (ext_q) begin
            case (rx_byte)
                8'h6B: hack_code = KEY_LEFT;
                8'h75: hack_code = KEY_UP;
                8'h74: hack_code = KEY_RIGHT;
                8'h72: hack_code = KEY_DOWN;
                8'h6C: hack_code = KEY_HOME;
                8'h69: hack_code = KEY_END;
                8'h7D: hack_code = KEY_PGUP;
                8'h7A: hack_code = KEY_PGDN;
                8'h70: hack_code = KEY_INSERT;
                8'h71: hack_code = KEY_DELETE;
                default: hack_code = '0;
            endcase
        end else begin
            case (rx_byte)
                8'h1C: hack_code = 8'd65;  8'h32: hack_code = 8'd66;
                8'h21: hack_code = 8'd67;  8'h23: hack_code = 8'd68;
                8'h24: hack_code = 8'd69;  8'h2B: hack_code = 8'd70;
                8'h34: hack_code = 8'd71;  8'h33: hack_code = 8'd72;
                8'h43: hack_code = 8'd73;  8'h3B: hack_code = 8'd74;
                8'h42: hack_code = 8'd75;  8'h4B: hack_code = 8'd76;
                8'h3A: hack_code = 8'd77;  8'h31: hack_code = 8'd78;
                8'h44: hack_code = 8'd79;  8'h4D: hack_code = 8'd80;
                8'h15: hack_code = 8'd81;  8'h2D: hack_code = 8'd82;
                8'h1B: hack_code = 8'd83;  8'h2C: hack_code = 8'd84;
                8'h3C: hack_code = 8'd85;  8'h2A: hack_code = 8'd86;
                8'h1D: hack_code = 8'd87;  8'h22: hack_code = 8'd88;
                8'h35: hack_code = 8'd89;  8'h1A: hack_code = 8'd90;
                8'h45: hack_code = 8'd48;  8'h16: hack_code = 8'd49;
                8'h1E: hack_code = 8'd50;  8'h26: hack_code = 8'd51;
                8'h25: hack_code = 8'd52;  8'h2E: hack_code = 8'd53;
                8'h36: hack_code = 8'd54;  8'h3D: hack_code = 8'd55;
                8'h3E: hack_code = 8'd56;  8'h46: hack_code = 8'd57;
                8'h29: hack_code = 8'd32;
                8'h5A: hack_code = KEY_NEWLINE;
                8'h66: hack_code = KEY_BACKSPACE;
                8'h76: hack_code = KEY_ESC;
                8'h05: hack_code = KEY_F1;  8'h06: hack_code = KEY_F2;
                8'h04: hack_code = KEY_F3;  8'h0C: hack_code = KEY_F4;
                8'h03: hack_code = KEY_F5;  8'h0B: hack_code = KEY_F6;
                8'h83: hack_code = KEY_F7;  8'h0A: hack_code = KEY_F8;
                8'h01: hack_code = KEY_F9;  8'h09: hack_code = KEY_F10;
                8'h78: hack_code = KEY_F11; 8'h07: hack_code = KEY_F12;
                default: hack_code = '0;
            endcase
        end
    end

    // Prefix flags and held-key register; key_event only on a real change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            kbd_q       <= '0;
            key_event_q <= 1'b0;
        end else begin
            key_event_q <= 1'b0;
            if (rx_valid) begin
                if (rx_byte == SC_E0) begin
                    ext_q <= 1'b1;
                end else if (rx_byte == SC_F0) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    if (!brk_q) begin
                        if (hack_code != '0 && hack_code != kbd_q) begin
                            kbd_q       <= hack_code;
                            key_event_q <= 1'b1;
                        end
                    end else if (hack_code == kbd_q && kbd_q != '0) begin
                        kbd_q       <= '0;
                        key_event_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign kbd_out   = {8'h00, kbd_q};
    assign key_event = key_event_q;

endmodule
